// File: rtl/bbox_crop_scale.sv
// bbox_crop_scale: crops an RGB frame to a box, nearest-neighbour rescales to OUT_W x OUT_H, writes grey samples
module bbox_crop_scale #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int OUT_W  = 28,
  parameter int OUT_H  = 28
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic                               done,
  output logic                               empty,
  input  logic [10:0]                        xMin,
  input  logic [10:0]                        xMax,
  input  logic [10:0]                        yMin,
  input  logic [10:0]                        yMax,
  output logic [23:0]                        rdaddr,
  input  logic [7:0]                         rddata,
  output logic [$clog2(OUT_W*OUT_H)-1:0]     wraddr,
  output logic [7:0]                         wrdata,
  output logic                               wren
);
  localparam int AW = $clog2(OUT_W*OUT_H);
  // wide enough for any 11-bit span plus the output step without wrapping
  localparam int CW = $clog2((WIDTH > HEIGHT ? WIDTH : HEIGHT) + 2048) + 1;
  localparam logic [CW-1:0] OW = CW'(OUT_W);
  localparam logic [CW-1:0] OH = CW'(OUT_H);
  localparam logic [CW-1:0] OW1 = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OH1 = CW'(OUT_H - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [AW-1:0] LAST_A = AW'(OUT_W*OUT_H - 1);

  typedef enum logic [3:0] {IDLE, SETUP, RD_R, RD_G, RD_B, RD_LAST, WRITE, ADV_Y, ADV_X, CLEAR, DONE} state_t;
  state_t state, next;

  logic [10:0]   x_min, x_max, y_min, y_max;
  logic [CW-1:0] wpix, hpix, src_x, src_r, i, j, acc_x, acc_y;
  logic [7:0]    r_val, g_val;
  logic [9:0]    sum;
  logic          bad, col_end, last;

  assign bad     = x_min > x_max || y_min > y_max;
  assign col_end = j == OH1;
  assign last    = col_end && i == OW1;
  assign sum     = {2'b0, r_val} + {1'b0, g_val, 1'b0} + {2'b0, rddata};
  assign rdaddr  = 24'(src_x) * 24'(HEIGHT*3) + 24'(src_r) * 24'd3 +
                   (state == RD_G ? 24'd1 : state == RD_B ? 24'd2 : 24'd0);

  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE: next = start ? SETUP : state;
      SETUP:      next = bad ? CLEAR : RD_R;
      RD_R:       next = RD_G;
      RD_G:       next = RD_B;
      RD_B:       next = RD_LAST;
      RD_LAST:    next = WRITE;
      WRITE:      next = last ? DONE : col_end ? ADV_X : ADV_Y;
      ADV_Y:      next = acc_y >= OH ? ADV_Y : RD_R;
      ADV_X:      next = acc_x >= OW ? ADV_X : RD_R;
      CLEAR:      next = wraddr == LAST_A ? DONE : CLEAR;
      default:    next = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      {x_min, x_max, y_min, y_max} <= '0;
      {wpix, hpix, src_x, src_r, i, j, acc_x, acc_y} <= '0;
      {r_val, g_val} <= '0;
      {done, empty, wren, wrdata} <= '0;
      wraddr <= '0;
    end else begin
      wren <= 1'b0;
      done <= next == DONE;
      unique case (state)
        IDLE, DONE: if (start) begin
          x_min <= xMin;
          x_max <= xMax;
          y_min <= yMin;
          y_max <= yMax;
          empty <= 1'b0;
        end
        SETUP: if (bad) begin
          empty  <= 1'b1;
          wren   <= 1'b1;
          wraddr <= '0;
          wrdata <= '0;
        end else begin
          wpix  <= CW'(x_max) - CW'(x_min) + ONE;
          hpix  <= CW'((y_max - y_min) / 11'd3) + ONE;
          src_x <= CW'(x_min);
          src_r <= CW'(y_min / 11'd3);
          {i, j, acc_x, acc_y} <= '0;
        end
        RD_G: r_val <= rddata;
        RD_B: g_val <= rddata;
        // blue arrives now, so the grey value is formed without a separate register
        RD_LAST: begin
          wren   <= 1'b1;
          wrdata <= sum[9:2];
          wraddr <= AW'(i * OH + j);
        end
        WRITE: if (col_end) begin
          j     <= '0;
          src_r <= CW'(y_min / 11'd3);
          acc_y <= '0;
          acc_x <= acc_x + wpix;
          i     <= i + ONE;
        end else begin
          j     <= j + ONE;
          acc_y <= acc_y + hpix;
        end
        ADV_Y: if (acc_y >= OH) begin
          acc_y <= acc_y - OH;
          src_r <= src_r + ONE;
        end
        ADV_X: if (acc_x >= OW) begin
          acc_x <= acc_x - OW;
          src_x <= src_x + ONE;
        end
        CLEAR: if (wraddr != LAST_A) begin
          wraddr <= wraddr + AW'(1);
          wren   <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bbox_crop_scale.sv
// tb_bbox_crop_scale: randomized crop/scale runs against a frame-memory model and a sample-level scoreboard
module tb_bbox_crop_scale;
  localparam int W = 100, H = 100, OW = 4, OH = 4, MEMN = W*H*3;

  logic clk = 0, rst_n = 0, start = 0;
  logic done, empty, wren;
  logic [10:0] xMin = 0, xMax = 0, yMin = 0, yMax = 0;
  logic [23:0] rdaddr;
  logic [7:0]  rddata = 0, wrdata;
  logic [3:0]  wraddr;
  logic [7:0]  mem [MEMN];
  int qa[$], qd[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  bbox_crop_scale #(.WIDTH(W), .HEIGHT(H), .OUT_W(OW), .OUT_H(OH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .empty(empty),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .rdaddr(rdaddr), .rddata(rddata), .wraddr(wraddr), .wrdata(wrdata), .wren(wren));

  always @(posedge clk) rddata <= (rdaddr < 24'(MEMN)) ? mem[rdaddr] : 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && wren) begin
      if (qa.size() == 0) chk("spurious wren", int'(wren), 0);
      else begin
        chk("wraddr", int'(wraddr), qa.pop_front());
        chk("wrdata", int'(wrdata), qd.pop_front());
      end
    end

  task automatic set_pix(input int x, input int r, input int rv, input int gv, input int bv);
    mem[x*H*3 + 3*r]     = 8'(rv);
    mem[x*H*3 + 3*r + 1] = 8'(gv);
    mem[x*H*3 + 3*r + 2] = 8'(bv);
  endtask

  task automatic fill_grey();
    for (int x = 0; x < W; x++)
      for (int r = 0; r < H; r++) set_pix(x, r, (x + r) & 255, (x + r) & 255, (x + r) & 255);
  endtask

  task automatic fill_rand();
    foreach (mem[k]) mem[k] = 8'($urandom);
  endtask

  // reference: pick the nearest-neighbour source pixel for each output cell by plain floor division
  task automatic model(input int xa, input int xb, input int ya, input int yb);
    if (xa > xb || ya > yb)
      for (int n = 0; n < OW*OH; n++) begin qa.push_back(n); qd.push_back(0); end
    else begin
      int w, h, x, r, b;
      w = xb - xa + 1;
      h = (yb - ya) / 3 + 1;
      for (int ci = 0; ci < OW; ci++)
        for (int cj = 0; cj < OH; cj++) begin
          x = xa + (ci * w) / OW;
          r = ya / 3 + (cj * h) / OH;
          b = x*H*3 + 3*r;
          qa.push_back(ci*OH + cj);
          qd.push_back((int'(mem[b]) + 2*int'(mem[b+1]) + int'(mem[b+2])) / 4);
        end
    end
  endtask

  task automatic kick(input int xa, input int xb, input int ya, input int yb);
    model(xa, xb, ya, yb);
    @(negedge clk);
    xMin = 11'(xa); xMax = 11'(xb); yMin = 11'(ya); yMax = 11'(yb);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string nm, input int exp_empty);
    int k = 0;
    while (!done && k < 3000) begin @(negedge clk); k++; end
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " empty"}, int'(empty), exp_empty);
    chk({nm, " pending writes"}, qa.size(), 0);
    qa.delete(); qd.delete();
  endtask

  task automatic run(input string nm, input int xa, input int xb, input int ya, input int yb, input bit inject);
    kick(xa, xb, ya, yb);
    if (inject) begin
      repeat (20) @(negedge clk);
      xMin = 11'd99; xMax = 11'd0; start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done(nm, (xa > xb || ya > yb) ? 1 : 0);
  endtask

  initial begin
    fill_grey();
    repeat (3) @(negedge clk);
    chk("rst rdaddr", int'(rdaddr), 0);
    chk("rst wraddr", int'(wraddr), 0);
    chk("rst wrdata", int'(wrdata), 0);
    chk("rst wren", int'(wren), 0);
    chk("rst done", int'(done), 0);
    chk("rst empty", int'(empty), 0);
    rst_n = 1;

    run("t1 grey box", 10, 13, 30, 39, 0);
    fill_rand();
    run("t2 downscale", 0, 7, 0, 21, 0);
    run("t3 upscale", 50, 51, 150, 153, 0);
    set_pix(60, 60, 40, 80, 120);
    run("t4 single px", 60, 60, 180, 180, 0);
    set_pix(60, 60, 255, 255, 255);
    run("t4 saturate", 60, 60, 180, 180, 0);
    run("t5 invalid", 99, 0, 0, 0, 0);

    fill_grey();
    kick(10, 13, 30, 39);
    repeat (15) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("abort wren", int'(wren), 0);
    chk("abort done", int'(done), 0);
    qa.delete(); qd.delete();
    rst_n = 1;
    run("t6 start ignored", 10, 13, 30, 39, 1);
    run("t6 rerun", 10, 13, 30, 39, 0);

    fill_rand();
    for (int n = 0; n < 24; n++) begin
      int xa, xb, ra, rb, t;
      xa = $urandom_range(0, W-1); xb = $urandom_range(0, W-1);
      ra = $urandom_range(0, H-1); rb = $urandom_range(0, H-1);
      if (n % 5 != 0) begin
        if (xa > xb) begin t = xa; xa = xb; xb = t; end
        if (ra > rb) begin t = ra; ra = rb; rb = t; end
      end
      run("random box", xa, xb, 3*ra, 3*rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
